dmem_wait_responder: RTL and testbench
======================================

# dmem_wait_responder

Data-memory responder on the far side of the core's memory-wait handshake. It accepts load/store requests from the Memory stage, asserts `mem_wait` for a configurable number of cycles so the pipeline controller freezes the pipeline, then completes the access against an internal word RAM and releases the stall with a one-cycle `mem_done`. It is the memory-side counterpart of the core's RAMBUFFER stall logic and replaces its fixed two-cycle wait approximation with an explicit state machine.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-address width; the RAM holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 2: number of wait cycles per access, legal range 1..15.

Ports (one clock `clk`, synchronous active-high reset `rst`):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  load request from the M stage.
- `mem_write`  in  1  store request from the M stage.
- `addr`  in  32  byte address. Bits `[ADDR_WIDTH+1:2]` select the word; all other bits are ignored.
- `wdata`  in  32  store data.
- `wstrb`  in  4  byte-enable mask for stores; bit i enables byte lane i.
- `mem_wait`  out  1  combinational stall to the pipeline controller.
- `mem_done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  registered load data.

## Operation
- States: IDLE, WAIT, DONE. A 4-bit down-counter `cnt` tracks the wait.
- A request is `mem_read | mem_write`.
- **IDLE:**
  - With a request present: latch `addr`, `wdata`, `wstrb` and the op type. A store takes priority when both request bits are high; the op is then a store only, with no read.
  - Load `cnt = LATENCY-1`.
  - Next state: DONE if `LATENCY == 1`, otherwise WAIT.
- **WAIT:**
  - If `cnt == 1` or the request has dropped, move on; otherwise decrement `cnt`.
  - If the request drops (abort), go to IDLE with no RAM write and no `rdata` update.
  - Otherwise, when `cnt == 1`, go to DONE.
  - On the edge entering DONE for a load, `rdata <= ram[latched word]`.
- **DONE:**
  - `mem_done = 1` and `mem_wait = 0`.
  - For a store, each byte lane with `wstrb[i] = 1` is written at the edge that ends DONE.
  - Next state is always IDLE.
- `mem_wait = (state == IDLE && request) || state == WAIT`.
- `rdata` holds its value until the next load completes. Stores never change `rdata`.
- A request still high in the IDLE cycle after DONE is treated as a new access. The pipeline advances on `mem_done`, so back-to-back memory instructions are separate accesses.
- Reset:
  - `state = IDLE`, `cnt = 0`, `rdata = 0`, `mem_done = 0`.
  - `mem_wait` follows its equation, so it is 1 during reset cycles if a request is present. The controller ignores it while in reset.
  - RAM contents are not cleared.
  - Reset in WAIT or DONE discards the pending access, including an uncommitted store.

## Timing
- A request first visible in cycle T:
  - `mem_wait = 1` in cycles T through T+LATENCY-1.
  - `mem_done = 1`, `mem_wait = 0`, and load data valid on `rdata` in cycle T+LATENCY.
  - A store is visible to reads from cycle T+LATENCY+1.
- Back-to-back accesses: the next request is accepted at T+LATENCY+1 and completes at T+2·LATENCY+1. One idle cycle separates completions.
- Read-after-write to the same word with back-to-back accesses returns the new data.
- The latched `addr`/`wdata`/`wstrb` are used for the whole access. Input changes after acceptance have no effect, except dropping the request, which aborts the access.
- `mem_done` is never high for two consecutive cycles.
- `mem_wait` and `mem_done` are never both high.

## Test plan
- **Reset:** `rst` high for 2 cycles with `mem_read = 1` → `mem_done = 0` and `rdata = 0`; after release, the first access starts in the first non-reset cycle.
- **Store then load, LATENCY=2:**
  - Store `addr = 0x10`, `wdata = 0xDEADBEEF`, `wstrb = 0xF` at T → `mem_wait = 1` at T and T+1, `mem_done` at T+2.
  - Load `0x10` at T+3 → `mem_done` at T+5 with `rdata = 0xDEADBEEF`.
- **Byte strobes:** store `0x11223344` to word 0x10 with `wstrb = 0b0101` over `0xDEADBEEF` → a later load returns `0xDE22BE44`.
- **Simultaneous read and write:** `mem_read = mem_write = 1`, `wdata = 0xA5A5A5A5` → the word is written, and `rdata` keeps its previous value at `mem_done`.
- **Abort and reset mid-op:**
  - `mem_write` dropped in WAIT → IDLE next cycle; the RAM word is unchanged and no `mem_done` is produced.
  - `rst` asserted in DONE → the store is discarded.
- **LATENCY=1 and address aliasing:** continuous `mem_read` → `mem_done` every other cycle; address `0x1010` with `ADDR_WIDTH = 10` aliases to word 4.

Source files
------------

// File: rtl/dmem_wait_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : dmem_wait_responder
// Description : Data-memory responder for the core's memory-wait handshake.
//               Stalls the pipeline via mem_wait for LATENCY cycles, then
//               completes the load/store against an internal word RAM and
//               signals completion with a one-cycle mem_done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_wait_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        mem_wait,
  output logic        mem_done,
  output logic [31:0] rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);
  localparam bit         C_SINGLE   = (LATENCY == 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_word;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_is_store;
  logic [31:0]           r_ram [0:(1<<ADDR_WIDTH)-1];

  logic                  w_req;
  logic [ADDR_WIDTH-1:0] w_in_word;
  logic [ADDR_WIDTH-1:0] w_rd_word;
  logic                  w_enter_done;
  logic                  w_load_done;
  logic                  w_ram_we;
  logic                  w_unused_addr;

  assign w_req     = mem_read | mem_write;
  assign w_in_word = addr[ADDR_WIDTH+1:2];

  // Address bits outside the word index are intentionally ignored.
  assign w_unused_addr = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

  // A load entering DONE straight from IDLE uses the live address and op;
  // from WAIT it uses the values latched at acceptance.
  assign w_load_done = w_enter_done &&
                       ((r_state == ST_IDLE) ? !mem_write : !r_is_store);
  assign w_rd_word   = (r_state == ST_IDLE) ? w_in_word : r_word;

  // Store commits at the edge ending DONE; a reset on that edge discards it.
  assign w_ram_we = (r_state == ST_DONE) && r_is_store && !rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and handshake outputs; dropping the request in WAIT aborts.
  always_comb begin
    w_next_state = r_state;
    mem_wait     = 1'b0;
    mem_done     = 1'b0;
    w_enter_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        mem_wait = w_req;
        if (w_req) begin
          w_next_state = C_SINGLE ? ST_DONE : ST_WAIT;
          w_enter_done = C_SINGLE;
        end
      end
      ST_WAIT: begin
        mem_wait = 1'b1;
        if (!w_req) begin
          w_next_state = ST_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_next_state = ST_DONE;
          w_enter_done = 1'b1;
        end
      end
      ST_DONE: begin
        mem_done     = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Latch the request at acceptance and run the wait down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 4'd0;
      r_word     <= '0;
      r_wdata    <= 32'd0;
      r_wstrb    <= 4'd0;
      r_is_store <= 1'b0;
    end else if (r_state == ST_IDLE && w_req) begin
      r_cnt      <= C_CNT_INIT;
      r_word     <= w_in_word;
      r_wdata    <= wdata;
      r_wstrb    <= wstrb;
      r_is_store <= mem_write;
    end else if (r_state == ST_WAIT && w_req && r_cnt != 4'd1) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Load data is captured on the edge entering DONE and held until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if (w_load_done) begin
      rdata <= r_ram[w_rd_word];
    end
  end

  // Byte-lane store into the word RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wstrb[i]) begin
          r_ram[r_word][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_wait_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dmem_wait_responder
// Description : Scoreboard bench for dmem_wait_responder. Stimulus pushes the
//               hand-computed rdata expected at each mem_done; monitors pop
//               and compare whenever a completion appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_wait_responder;

  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // LATENCY=2 instance
  logic        rst = 1'b1, mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic        mem_wait, mem_done;
  logic [31:0] rdata;

  // LATENCY=1 instance
  logic        rst1 = 1'b1, mr1 = 1'b0, mw1 = 1'b0;
  logic [31:0] addr1 = 32'd0, wdata1 = 32'd0;
  logic [3:0]  wstrb1 = 4'd0;
  logic        wait1, done1;
  logic [31:0] rdata1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_q1[$];
  logic prev_done1 = 1'b0;

  dmem_wait_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .mem_wait(mem_wait), .mem_done(mem_done), .rdata(rdata)
  );

  dmem_wait_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .mem_read(mr1), .mem_write(mw1),
    .addr(addr1), .wdata(wdata1), .wstrb(wstrb1),
    .mem_wait(wait1), .mem_done(done1), .rdata(rdata1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the LATENCY=2 instance.
  always @(negedge clk) begin
    if (mem_done === 1'b1) begin
      check("done_wait_exclusive", {31'd0, mem_wait}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got mem_done=1 expected no completion");
      end else begin
        check("rdata_at_done", rdata, exp_q.pop_front());
      end
    end
  end

  // Scoreboard monitor for the LATENCY=1 instance.
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      check("done1_not_consecutive", {31'd0, prev_done1}, 32'd0);
      check("done1_wait_exclusive", {31'd0, wait1}, 32'd0);
      if (exp_q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done1: got done1=1 expected no completion");
      end else begin
        check("rdata1_at_done", rdata1, exp_q1.pop_front());
      end
    end
    prev_done1 = done1;
  end

  // One access on the LATENCY=2 instance; exp_rd is rdata at mem_done.
  task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp_rd, input bit rst_in_done);
    int cyc;
    int waits;
    bit seen;
    @(posedge clk);
    #1;
    rst = 1'b0; mem_write = wr; mem_read = rd; addr = a; wdata = d; wstrb = s;
    exp_q.push_back(exp_rd);
    cyc = 0; waits = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      if (mem_done === 1'b1) begin
        seen = 1'b1;
      end else begin
        cyc++;
        if (mem_wait === 1'b1) waits++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no mem_done in %0d cycles expected %0d", cyc, LAT);
      void'(exp_q.pop_back());
    end else begin
      check("latency", cyc, LAT);
      check("wait_cycles", waits, LAT);
    end
    if (rst_in_done) begin
      #1;
      rst = 1'b1; mem_write = 1'b0; mem_read = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    mem_write = 1'b0; mem_read = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("idle_wait", {31'd0, mem_wait}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a read request present.
    rst = 1'b1; mem_read = 1'b1; addr = 32'h10;
    repeat (2) begin
      @(negedge clk);
      check("reset_done", {31'd0, mem_done}, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      check("reset_wait", {31'd0, mem_wait}, 32'd1);
    end

    // First access starts in the first non-reset cycle.
    access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Byte strobes 0101 over DEADBEEF, then back-to-back read-after-write.
    access(1'b1, 1'b0, 32'h10, 32'h11223344, 4'b0101, 32'hDEADBEEF, 1'b0);
    access(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);

    // Simultaneous read and write: store only, rdata unchanged.
    access(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 32'hDE22BE44, 1'b0);
    access(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);
    idle(2);

    // Abort: store dropped during WAIT.
    @(posedge clk);
    #1;
    mem_write = 1'b1; addr = 32'h20; wdata = 32'h12345678; wstrb = 4'hF;
    @(negedge clk);
    check("abort_wait_accept", {31'd0, mem_wait}, 32'd1);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    @(negedge clk);
    check("abort_wait_in_wait", {31'd0, mem_wait}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("abort_wait_after", {31'd0, mem_wait}, 32'd0);
      check("abort_no_done", {31'd0, mem_done}, 32'd0);
    end
    access(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);

    // Reset asserted during DONE discards the store.
    access(1'b1, 1'b0, 32'h20, 32'hCAFEF00D, 4'hF, 32'hA5A5A5A5, 1'b1);
    check("rdata_after_reset", rdata, 32'h0);
    access(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);

    // Address aliasing: 0x1010 maps to word 4, same as byte address 0x10.
    access(1'b1, 1'b0, 32'h1010, 32'h0BADF00D, 4'hF, 32'hA5A5A5A5, 1'b0);
    access(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);
    idle(1);

    // LATENCY=1 instance: store through an aliased address, then stream reads.
    @(posedge clk);
    #1;
    rst1 = 1'b0; mw1 = 1'b1; addr1 = 32'h1010; wdata1 = 32'h600DCAFE; wstrb1 = 4'hF;
    exp_q1.push_back(32'h0);
    @(negedge clk);
    check("lat1_wait", {31'd0, wait1}, 32'd1);
    @(negedge clk);
    check("lat1_store_done", {31'd0, done1}, 32'd1);
    @(posedge clk);
    #1;
    mw1 = 1'b0; mr1 = 1'b1; addr1 = 32'h10;
    repeat (4) exp_q1.push_back(32'h600DCAFE);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("lat1_done_pattern", {31'd0, done1}, 32'(k % 2));
    end
    @(posedge clk);
    #1;
    mr1 = 1'b0;
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 32'(exp_q.size() + exp_q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
